// File: rtl/vlan_tag_editor.sv
// ---------------------------------------------------------------------------
// vlan_tag_editor
//
// Per-packet 802.1Q tag editor on the 64-bit user data path. Each packet is
// preceded by a VLAN module-header word (ctrl == VLAN_CTRL) carrying:
//   data[15:0]  TCI
//   data[17:16] op: 0 = pass, 1 = add, 2 = rewrite, 3 = pass
// The header word is always consumed and never forwarded.
//
// Add inserts {TPID, TCI} after the MAC addresses. Every later byte moves four
// positions, so the data path runs with a 32-bit carry register. The IOQ
// module header has its lengths raised by four bytes. It uses this layout:
// [63:48] dst port, [47:32] word length, [31:16] src port, [15:0] byte length.
// Rewrite replaces the TCI of an already tagged frame.
//
// Control bytes follow the usual datapath convention: ctrl bit 7 marks
// data[63:56] as the last valid byte and bit 0 marks data[7:0].
//
// Optional feature macro: VLAN_EDIT_REWRITE_EN
//   defined   : op 2 rewrites the TCI of tagged frames and the rewrite_miss
//               port exists.
//   undefined : op 2 behaves like add and there is no rewrite_miss port.
//
// Ports
//   clk           sole clock
//   reset         asynchronous, active-low reset
//   in_data/in_ctrl/in_wr     upstream word, control and write strobe
//   in_rdy        high while the input FIFO has at least two free entries
//   out_data/out_ctrl/out_wr  registered downstream word, control and strobe
//   out_rdy       downstream ready
//   err_short     one-cycle pulse: the packet ended before the TCI word
//   rewrite_miss  one-cycle pulse: rewrite requested on an untagged frame
// ---------------------------------------------------------------------------

`ifndef VLAN_CTRL_WORD
`define VLAN_CTRL_WORD 8'h42
`endif

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif

module vlan_tag_editor #(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int                    FIFO_DEPTH_BITS = 3,
    parameter logic [CTRL_WIDTH-1:0] VLAN_CTRL       = `VLAN_CTRL_WORD,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL        = `IO_QUEUE_STAGE_NUM,
    parameter logic [15:0]           TPID            = 16'h8100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  err_short
`ifdef VLAN_EDIT_REWRITE_EN
    ,
    output logic                  rewrite_miss
`endif
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] CNT_FULL = (FIFO_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_BITS:0] CNT_NEAR = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        FIND_HDR,
        WAIT_SOP,
        EDIT,
        SHIFT,
        FLUSH,
        PASS
    } state_t;

    state_t state, state_nxt;

    // Input FIFO
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]       wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]         fifo_count;
    logic                             fifo_empty, fifo_full, fifo_nearly_full;
    logic                             wr_en, rd_en;
    logic [DATA_WIDTH-1:0]            d;
    logic [CTRL_WIDTH-1:0]            c;

    // Per-packet registers
    logic [15:0]           tci_q, tci_nxt;
    logic [1:0]            op_q, op_nxt;
    logic [31:0]           latch_q, latch_nxt;
    logic [CTRL_WIDTH-1:0] lctrl_q, lctrl_nxt;

    // Next values of the registered outputs
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [CTRL_WIDTH-1:0] ctrl_nxt;
    logic                  wr_nxt;
    logic                  err_nxt;
`ifdef VLAN_EDIT_REWRITE_EN
    logic                  miss_nxt;
`endif

    // IOQ header with the four tag bytes added (16-bit wrap is intended)
    logic [15:0] ioq_len_new;
    logic [15:0] ioq_words_new;

    // An op that edits the frame: add or rewrite (op 2 is add when rewrite is off)
    function automatic logic op_edits(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

    function automatic logic op_adds(input logic [1:0] op);
`ifdef VLAN_EDIT_REWRITE_EN
        return op == 2'd1;
`else
        return (op == 2'd1) || (op == 2'd2);
`endif
    endfunction

    assign fifo_empty       = (fifo_count == '0);
    assign fifo_full        = (fifo_count == CNT_FULL);
    assign fifo_nearly_full = (fifo_count >= CNT_NEAR);
    assign in_rdy           = !fifo_nearly_full;
    assign wr_en            = in_wr && !fifo_full;
    assign {c, d}           = fifo_mem[rd_ptr];

    // FLUSH emits a word built purely from the carry register, so it never
    // reads the FIFO. Every other state reads one word when one can be sent.
    assign rd_en = (state != FLUSH) && out_rdy && !fifo_empty;

    assign ioq_len_new   = d[15:0] + 16'd4;
    assign ioq_words_new = 16'((17'(ioq_len_new) + 17'd7) >> 3);

    // FIFO storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {in_ctrl, in_data};
        end
    end

    // FIFO pointers and occupancy. A write to a full FIFO is dropped, and a
    // read and a write in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FIND_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Each FIFO-driven state moves only on a word actually
    // read. FLUSH only needs downstream to be ready.
    always_comb begin
        state_nxt = state;
        case (state)
            FIND_HDR: begin
                if (rd_en && c == VLAN_CTRL && op_edits(d[17:16])) begin
                    state_nxt = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (rd_en && c == '0) begin
                    state_nxt = EDIT;
                end
            end
            EDIT: begin
                if (rd_en) begin
                    if (c != '0) begin
                        state_nxt = FIND_HDR;
                    end else if (op_adds(op_q)) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = PASS;
                    end
                end
            end
            SHIFT: begin
                if (rd_en) begin
                    if (c[7:4] != '0) begin
                        state_nxt = FIND_HDR;
                    end else if (c[3:0] != '0) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_rdy) begin
                    state_nxt = FIND_HDR;
                end
            end
            PASS: begin
                if (rd_en && c != '0) begin
                    state_nxt = FIND_HDR;
                end
            end
            default: state_nxt = FIND_HDR;
        endcase
    end

    // Output and datapath logic. This computes the word to present next cycle
    // and the updates to the per-packet registers. A consumed header word
    // leaves wr_nxt low, which makes the one-cycle bubble downstream.
    always_comb begin
        data_nxt  = out_data;
        ctrl_nxt  = out_ctrl;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
`ifdef VLAN_EDIT_REWRITE_EN
        miss_nxt  = 1'b0;
`endif
        tci_nxt   = tci_q;
        op_nxt    = op_q;
        latch_nxt = latch_q;
        lctrl_nxt = lctrl_q;
        case (state)
            FIND_HDR: begin
                if (rd_en) begin
                    if (c == VLAN_CTRL) begin
                        tci_nxt = d[15:0];
                        op_nxt  = d[17:16];
                    end else begin
                        wr_nxt   = 1'b1;
                        data_nxt = d;
                        ctrl_nxt = c;
                    end
                end
            end
            WAIT_SOP: begin
                // The first header wins, so later VLAN headers are discarded.
                if (rd_en && c != VLAN_CTRL) begin
                    wr_nxt   = 1'b1;
                    data_nxt = d;
                    ctrl_nxt = c;
                    if (c == IOQ_CTRL && op_adds(op_q)) begin
                        data_nxt = {d[63:48], ioq_words_new, d[31:16], ioq_len_new};
                    end
                end
            end
            EDIT: begin
                if (rd_en) begin
                    wr_nxt   = 1'b1;
                    data_nxt = d;
                    ctrl_nxt = c;
                    if (c != '0) begin
                        // The frame ended before the TCI slot. Any IOQ length
                        // already sent downstream keeps its +4.
                        err_nxt = 1'b1;
                    end else begin
`ifdef VLAN_EDIT_REWRITE_EN
                        if (op_adds(op_q)) begin
                            data_nxt  = {d[63:32], TPID, tci_q};
                            latch_nxt = d[31:0];
                        end else if (d[31:16] == TPID) begin
                            data_nxt = {d[63:16], tci_q};
                        end else begin
                            miss_nxt = 1'b1;
                        end
`else
                        data_nxt  = {d[63:32], TPID, tci_q};
                        latch_nxt = d[31:0];
`endif
                    end
                end
            end
            SHIFT: begin
                // The frame runs four bytes late. The final byte either still
                // fits in this word, or it spills into one extra FLUSH word.
                if (rd_en) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = {latch_q, d[63:32]};
                    latch_nxt = d[31:0];
                    ctrl_nxt  = '0;
                    if (c[7:4] != '0) begin
                        ctrl_nxt = c >> 4;
                    end else if (c[3:0] != '0) begin
                        lctrl_nxt = c;
                    end
                end
            end
            FLUSH: begin
                if (out_rdy) begin
                    wr_nxt   = 1'b1;
                    data_nxt = {latch_q, 32'h0};
                    ctrl_nxt = lctrl_q << 4;
                end
            end
            PASS: begin
                if (rd_en) begin
                    wr_nxt   = 1'b1;
                    data_nxt = d;
                    ctrl_nxt = c;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and per-packet registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data     <= '0;
            out_ctrl     <= '0;
            out_wr       <= 1'b0;
            err_short    <= 1'b0;
`ifdef VLAN_EDIT_REWRITE_EN
            rewrite_miss <= 1'b0;
`endif
            tci_q        <= '0;
            op_q         <= '0;
            latch_q      <= '0;
            lctrl_q      <= '0;
        end else begin
            out_data     <= data_nxt;
            out_ctrl     <= ctrl_nxt;
            out_wr       <= wr_nxt;
            err_short    <= err_nxt;
`ifdef VLAN_EDIT_REWRITE_EN
            rewrite_miss <= miss_nxt;
`endif
            tci_q        <= tci_nxt;
            op_q         <= op_nxt;
            latch_q      <= latch_nxt;
            lctrl_q      <= lctrl_nxt;
        end
    end

endmodule

// File: tb/tb_vlan_tag_editor.sv
// ---------------------------------------------------------------------------
// tb_vlan_tag_editor
//
// Scoreboard bench for vlan_tag_editor. Packets are described as byte arrays.
// The expected output is formed by byte insertion or replacement on those
// arrays, and the result is then regrouped into 64-bit words. A monitor pops
// an expectation for every out_wr word the DUT presents.
// Honours VLAN_EDIT_REWRITE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_vlan_tag_editor;

    localparam logic [7:0]  VLAN_C = 8'h42;
    localparam logic [7:0]  IOQ_C  = 8'hff;
    localparam logic [15:0] TPID   = 16'h8100;
`ifdef VLAN_EDIT_REWRITE_EN
    localparam bit RW_EN = 1'b1;
`else
    localparam bit RW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        err_short;
    logic        rewrite_miss;

    always #5 clk = ~clk;

    vlan_tag_editor #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8),
        .FIFO_DEPTH_BITS(3),
        .VLAN_CTRL(VLAN_C),
        .IOQ_CTRL(IOQ_C),
        .TPID(TPID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .in_wr(in_wr),
        .in_rdy(in_rdy),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .out_wr(out_wr),
        .out_rdy(out_rdy),
        .err_short(err_short)
`ifdef VLAN_EDIT_REWRITE_EN
        ,
        .rewrite_miss(rewrite_miss)
`endif
    );

`ifndef VLAN_EDIT_REWRITE_EN
    assign rewrite_miss = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } word_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        err;
        logic        miss;
    } exp_t;

    exp_t  expq[$];
    word_t inq[$];
    word_t packed_q[$];

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    bit mon_en = 1'b0;

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Groups a byte stream into words; the last word flags its final byte
    task automatic packBytes(input logic [7:0] b[$]);
        int n;
        word_t x;
        n = b.size();
        packed_q.delete();
        for (int w = 0; w * 8 < n; w++) begin
            x.data = '0;
            for (int j = 0; j < 8; j++) begin
                if (w * 8 + j < n) x.data[63-8*j -: 8] = b[w*8+j];
            end
            x.ctrl = ((w + 1) * 8 >= n) ? (8'h80 >> ((n - 1) % 8)) : 8'h00;
            packed_q.push_back(x);
        end
    endtask

    // Builds the input words of one packet into inq and queues the expected output
    task automatic buildPacket(input logic [1:0] op, input logic [15:0] tci, input logic [15:0] ioq_len,
                               input bit dup, input int len, input logic [15:0] etype);
        logic [7:0]  fr[$];
        logic [7:0]  ob[$];
        word_t       w;
        exp_t        e;
        bit          is_add, is_rw, short_pkt, err, miss;
        logic [15:0] dst, src, nl;
        is_add    = (op == 2'd1) || (op == 2'd2 && !RW_EN);
        is_rw     = (op == 2'd2) && RW_EN;
        short_pkt = (len <= 16);
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        if (len > 13) begin
            fr[12] = etype[15:8];
            fr[13] = etype[7:0];
        end
        inq.delete();
        w.data = {32'($urandom), 14'($urandom), op, tci};
        w.ctrl = VLAN_C;
        inq.push_back(w);
        if (dup && (is_add || is_rw)) begin
            w.data = {32'($urandom), 14'($urandom), 2'($urandom), ~tci};
            inq.push_back(w);
        end
        dst    = 16'($urandom);
        src    = 16'($urandom);
        w.data = {dst, 16'((32'(ioq_len) + 7) / 8), src, ioq_len};
        w.ctrl = IOQ_C;
        inq.push_back(w);
        e.data = w.data;
        e.ctrl = IOQ_C;
        e.err  = 1'b0;
        e.miss = 1'b0;
        if (is_add) begin
            nl     = ioq_len + 16'd4;
            e.data = {dst, 16'((32'(nl) + 7) / 8), src, nl};
        end
        expq.push_back(e);
        packBytes(fr);
        foreach (packed_q[i]) inq.push_back(packed_q[i]);

        err  = 1'b0;
        miss = 1'b0;
        if ((is_add || is_rw) && short_pkt) begin
            err = 1'b1;
            ob  = fr;
        end else if (is_add) begin
            for (int i = 0; i < len; i++) begin
                if (i == 12) begin
                    ob.push_back(TPID[15:8]);
                    ob.push_back(TPID[7:0]);
                    ob.push_back(tci[15:8]);
                    ob.push_back(tci[7:0]);
                end
                ob.push_back(fr[i]);
            end
        end else begin
            ob = fr;
            if (is_rw) begin
                if (etype == TPID) begin
                    ob[14] = tci[15:8];
                    ob[15] = tci[7:0];
                end else begin
                    miss = 1'b1;
                end
            end
        end
        packBytes(ob);
        foreach (packed_q[i]) begin
            e.data = packed_q[i].data;
            e.ctrl = packed_q[i].ctrl;
            e.err  = (i == 1) && err;
            e.miss = (i == 1) && miss;
            expq.push_back(e);
        end
    endtask

    // Drives one word, waiting (bounded) for in_rdy
    task automatic sendWord(input word_t w);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_rdy && n < 2000) begin
            in_wr = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_rdy_timeout: got 0 expected 1");
            in_wr = 1'b0;
        end else begin
            in_wr   = 1'b1;
            in_data = w.data;
            in_ctrl = w.ctrl;
        end
    endtask

    task automatic sendAll();
        foreach (inq[i]) sendWord(inq[i]);
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] tci, input logic [15:0] ioq_len,
                                 input bit dup, input int len, input logic [15:0] etype);
        buildPacket(op, tci, ioq_len, dup, len, etype);
        sendAll();
    endtask

    // Waits for the scoreboard to empty, within a cycle budget
    task automatic waitDrain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(expq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Downstream ready pattern: always, toggling, random, or held low
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ~out_rdy;
                2:       out_rdy = ($urandom_range(0, 3) != 0);
                default: out_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: compares each presented word against the scoreboard
    initial begin
        logic rdy_s;
        exp_t e;
        forever begin
            @(posedge clk);
            rdy_s = out_rdy;
            #1;
            if (mon_en && reset) begin
                if (out_wr) begin
                    checkOutput("wr_needs_rdy", 64'(rdy_s), 64'd1);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got %h/%h expected none", out_data, out_ctrl);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("out_data", out_data, e.data);
                        checkOutput("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                        checkOutput("err_short", 64'(err_short), 64'(e.err));
                        checkOutput("rewrite_miss", 64'(rewrite_miss), 64'(e.miss));
                    end
                end else if (err_short || rewrite_miss) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stray_pulse: got err=%b miss=%b expected 0", err_short, rewrite_miss);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [15:0] et;
        int          len;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_out_wr", 64'(out_wr), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst_err_short", 64'(err_short), 64'd0);
        checkOutput("rst_rewrite_miss", 64'(rewrite_miss), 64'd0);
        checkOutput("rst_in_rdy", 64'(in_rdy), 64'd1);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed packets
        $display("[TB] add, 64-byte frame");
        applyStimulus(2'd1, 16'h2005, 16'd64, 1'b0, 64, 16'h0800);
        waitDrain();
        $display("[TB] add, 61-byte frame");
        applyStimulus(2'd1, 16'h0123, 16'd61, 1'b0, 61, 16'h0800);
        waitDrain();
        $display("[TB] rewrite, tagged and untagged");
        applyStimulus(2'd2, 16'h0FFE, 16'd64, 1'b0, 64, TPID);
        waitDrain();
        applyStimulus(2'd2, 16'h0FFE, 16'd70, 1'b0, 70, 16'h0800);
        waitDrain();
        $display("[TB] short packet, then recovery");
        applyStimulus(2'd1, 16'h0777, 16'd16, 1'b0, 16, 16'h0800);
        applyStimulus(2'd1, 16'h0abc, 16'd40, 1'b0, 40, 16'h0800);
        waitDrain();
        $display("[TB] duplicate header, length wrap, pass");
        applyStimulus(2'd1, 16'h1111, 16'd50, 1'b1, 50, 16'h0800);
        applyStimulus(2'd1, 16'h2222, 16'hFFFE, 1'b0, 33, 16'h0800);
        applyStimulus(2'd3, 16'h3333, 16'd30, 1'b0, 30, TPID);
        waitDrain();

        // FIFO fill with downstream stalled
        $display("[TB] fifo fill");
        rdy_mode = 3;
        repeat (2) @(negedge clk);
        buildPacket(2'd1, 16'h0456, 16'd80, 1'b0, 80, 16'h0800);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("in_rdy_filling", 64'(in_rdy), 64'd1);
            in_wr   = 1'b1;
            in_data = inq[k].data;
            in_ctrl = inq[k].ctrl;
        end
        @(negedge clk);
        in_wr = 1'b0;
        checkOutput("in_rdy_nearly_full", 64'(in_rdy), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("in_rdy_held", 64'(in_rdy), 64'd0);
        rdy_mode = 1;
        for (int k = 7; k < inq.size(); k++) sendWord(inq[k]);
        @(negedge clk);
        in_wr = 1'b0;
        waitDrain();

        // Toggling backpressure with back-to-back packets
        $display("[TB] toggling backpressure");
        for (int p = 0; p < 6; p++) begin
            applyStimulus(2'(p % 3), 16'($urandom), 16'(40 + p * 5), 1'b0, 40 + p * 5, (p % 2 == 0) ? TPID : 16'h0800);
        end
        waitDrain();

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        rdy_mode = 0;
        @(negedge clk);
        buildPacket(2'd1, 16'h0999, 16'd80, 1'b0, 80, 16'h0800);
        for (int k = 0; k < 6; k++) sendWord(inq[k]);
        @(negedge clk);
        in_wr  = 1'b0;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("midrst_out_wr", 64'(out_wr), 64'd0);
        checkOutput("midrst_out_data", out_data, 64'd0);
        checkOutput("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("midrst_err_short", 64'(err_short), 64'd0);
        checkOutput("midrst_in_rdy", 64'(in_rdy), 64'd1);
        expq.delete();
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        applyStimulus(2'd1, 16'h0aaa, 16'd48, 1'b0, 48, 16'h0800);
        waitDrain();

        // Randomised traffic with random downstream stalls
        $display("[TB] random traffic");
        rdy_mode = 2;
        for (int p = 0; p < 120; p++) begin
            op  = 2'($urandom);
            len = $urandom_range(9, 100);
            case ($urandom % 3)
                0:       et = TPID;
                1:       et = 16'h0800;
                default: et = 16'($urandom);
            endcase
            applyStimulus(op, 16'($urandom), ($urandom % 2 == 0) ? 16'(len) : 16'($urandom),
                          ($urandom % 4 == 0), len, et);
        end
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
